imem_loader: RTL and testbench
==============================

# imem_loader

Serial program loader that fills the instruction memory before the multi-cycle RISC-V core runs. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each word is written to consecutive instruction-memory addresses, and the core is held in reset until the all-zero terminator word is written. This block writes instruction memory; the core's fetch stage is the reader. The terminator is the same all-zero instruction the core treats as end of program.

## Interface
Parameters:
- ADDR_W, default 5, instruction-memory word-address width (2^ADDR_W words).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request to begin or restart a load.
- byte_valid  in  1  byte_data holds a valid byte.
- byte_data  in  8  incoming program byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction-memory write enable (one cycle per word).
- imem_addr  out  ADDR_W  word address being written.
- imem_wdata  out  32  assembled instruction word.
- core_rst_n  out  1  active-low reset to the core; 0 while not loaded.
- done  out  1  load completed with terminator.
- err  out  1  memory filled without a terminator.
- word_count  out  ADDR_W+1  number of words written in the current load, terminator included.

## Operation
- Reset values: byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst_n=0, done=0, err=0, word_count=0, state=IDLE, byte index=0.
- A byte is transferred only when byte_valid=1 and byte_ready=1. byte_data is sampled at that clock edge.
- Assembly is little-endian:
  - byte index 0 goes to wdata[7:0], 1 to [15:8], 2 to [23:16], 3 to [31:24].
  - The index wraps 3→0.
- States:
  - IDLE: byte_ready=0. start=1 → RECV with imem_addr=0, word_count=0, index=0, done=0, err=0.
  - RECV: byte_ready=1, core_rst_n=0. On acceptance of byte index 3 → WRITE. start is ignored.
  - WRITE: exactly one cycle with imem_we=1, byte_ready=0. Any byte offered in this cycle is not consumed. At the end of the cycle word_count increments, and the next state is chosen in this priority:
    - wdata==0 → DONE.
    - else imem_addr==2^ADDR_W-1 → ERR.
    - else imem_addr increments → RECV.
  - DONE: done=1, core_rst_n=1, byte_ready=0. Holds until start (→ RECV, core_rst_n=0) or rst.
  - ERR: err=1, core_rst_n=0, byte_ready=0. start → RECV.
- The terminator is always written to memory, so the core fetches it and halts.
- imem_wdata and imem_addr keep their last values outside WRITE. Memory must only honour them when imem_we=1.
- Reset mid-load discards the partial word. Memory contents already written are not cleared.

## Timing
- All outputs are registered.
- Maximum throughput is 1 byte per cycle, so a word takes at least 5 cycles (4 accept + 1 WRITE).
- imem_we asserts in the cycle after the edge that accepted byte 3.
- done=1 and core_rst_n=1 assert on the first cycle after the terminator's WRITE cycle.
- err asserts on the first cycle after the final WRITE that reaches the last address.
- start in DONE/ERR: core_rst_n=0, done=0, err=0, and byte_ready=1 from the next cycle.
- start in IDLE: byte_ready=1 from the next cycle.
- rst=0 overrides everything at the next edge, including a simultaneous start or byte transfer.

## Test plan
- Load bytes 93 00 50 00 | 13 81 10 00 | 00 00 00 00 at 1 byte/cycle → writes (0,0x00500093), (1,0x00108113), (2,0x00000000); word_count=3; done=1 and core_rst_n=1 one cycle after the third write.
- Byte order: bytes 0x78,0x56,0x34,0x12 → imem_wdata=0x12345678 at imem_addr=0. Random byte_valid gaps give identical writes, and only valid&ready cycles advance the index.
- byte_valid held high through the WRITE cycle with byte 0xAA pending → 0xAA is not consumed in WRITE and becomes byte 0 of the next word.
- ADDR_W=2 with 4 nonzero words → writes at addresses 0..3, then err=1, done=0, core_rst_n=0, byte_ready=0. No fifth write occurs.
- rst=0 after 2 bytes of word 1 → all outputs return to reset values. A new start plus 4 bytes writes the new word at address 0 with no stale bytes.
- start while in DONE → core_rst_n=0 and done=0 next cycle. The reload writes from address 0, and word_count restarts at 0.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bundle for the program loader.
// master is the host side (drives bytes/start); slave is the loader itself.
interface imem_loader_if #(
  parameter int ADDR_W = 5
);
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst_n;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   word_count;

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata,
    input  core_rst_n, done, err, word_count
  );

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata,
    output core_rst_n, done, err, word_count
  );
endinterface

// File: rtl/imem_loader.sv
// Serial program loader: assembles little-endian words from a byte stream,
// writes them to instruction memory and releases the core on the zero terminator.
module imem_loader #(
  parameter int ADDR_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  imem_loader_if.slave    bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    DONE,
    ERR
  } state_t;

  state_t            state, state_nx;
  logic [1:0]        idx, idx_nx;
  logic [23:0]       asm_q, asm_nx;    // bytes 0..2; byte 3 lands directly in wdata
  logic [31:0]       wdata_q, wdata_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [ADDR_W:0]   count_q, count_nx;

  logic byte_ready_q;
  logic imem_we_q;
  logic core_rst_n_q;
  logic done_q;
  logic err_q;
  logic accept;

  assign accept = bus.byte_valid & byte_ready_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_nx = state;
    idx_nx   = idx;
    asm_nx   = asm_q;
    wdata_nx = wdata_q;
    addr_nx  = addr_q;
    count_nx = count_q;

    case (state)
      IDLE, DONE, ERR: begin
        if (bus.start) begin
          state_nx = RECV;
          idx_nx   = 2'd0;
          addr_nx  = '0;
          count_nx = '0;
        end
      end

      RECV: begin
        if (accept) begin
          idx_nx = idx + 2'd1;
          case (idx)
            2'd0:    asm_nx[7:0]   = bus.byte_data;
            2'd1:    asm_nx[15:8]  = bus.byte_data;
            2'd2:    asm_nx[23:16] = bus.byte_data;
            default: begin
              wdata_nx = {bus.byte_data, asm_q};
              state_nx = WRITE;
            end
          endcase
        end
      end

      WRITE: begin
        count_nx = count_q + 1'b1;
        if (wdata_q == 32'd0) begin
          state_nx = DONE;
        end else if (addr_q == LAST_ADDR) begin
          state_nx = ERR;
        end else begin
          addr_nx  = addr_q + 1'b1;
          state_nx = RECV;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // Outputs are flops loaded from the next state so they line up with it.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!rst) begin
      state        <= IDLE;
      idx          <= 2'd0;
      asm_q        <= '0;
      wdata_q      <= '0;
      addr_q       <= '0;
      count_q      <= '0;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state        <= state_nx;
      idx          <= idx_nx;
      asm_q        <= asm_nx;
      wdata_q      <= wdata_nx;
      addr_q       <= addr_nx;
      count_q      <= count_nx;
      byte_ready_q <= (state_nx == RECV);
      imem_we_q    <= (state_nx == WRITE);
      core_rst_n_q <= (state_nx == DONE);
      done_q       <= (state_nx == DONE);
      err_q        <= (state_nx == ERR);
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.core_rst_n = core_rst_n_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.word_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench: two loaders (ADDR_W=5 and ADDR_W=2) share one byte stream
// and are compared cycle by cycle against a behavioural model plus write logs.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  bit         mon_on = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(5)) bus5 ();
  imem_loader_if #(.ADDR_W(2)) bus2 ();

  assign bus5.start      = start;
  assign bus5.byte_valid = byte_valid;
  assign bus5.byte_data  = byte_data;
  assign bus2.start      = start;
  assign bus2.byte_valid = byte_valid;
  assign bus2.byte_data  = byte_data;

  imem_loader #(.ADDR_W(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));
  imem_loader #(.ADDR_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {P_IDLE, P_RECV, P_WRITE, P_DONE, P_ERR} phase_e;
  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  phase_e      ph[2]    = '{P_IDLE, P_IDLE};
  int          nb[2]    = '{0, 0};
  logic [31:0] part[2]  = '{32'd0, 32'd0};
  logic [31:0] wlast[2] = '{32'd0, 32'd0};
  int          maddr[2] = '{0, 0};
  int          mcnt[2]  = '{0, 0};
  int          aw[2]    = '{5, 2};
  wr_t         log5[$];
  wr_t         log2[$];

  task automatic model_step(input int d, input logic rdy, input logic we, input logic crn,
                            input logic dn, input logic er, input int addr,
                            input logic [31:0] wd, input int cnt);
    string p;
    int    last;
    p    = (d == 0) ? "a5" : "a2";
    last = (1 << aw[d]) - 1;
    check({p, ".byte_ready"}, 32'(rdy), 32'(ph[d] == P_RECV));
    check({p, ".imem_we"},    32'(we),  32'(ph[d] == P_WRITE));
    check({p, ".core_rst_n"}, 32'(crn), 32'(ph[d] == P_DONE));
    check({p, ".done"},       32'(dn),  32'(ph[d] == P_DONE));
    check({p, ".err"},        32'(er),  32'(ph[d] == P_ERR));
    check({p, ".imem_addr"},  addr,     maddr[d]);
    check({p, ".imem_wdata"}, wd,       wlast[d]);
    check({p, ".word_count"}, cnt,      mcnt[d]);

    if (!rst) begin
      ph[d] = P_IDLE; nb[d] = 0; maddr[d] = 0; mcnt[d] = 0; wlast[d] = 32'd0;
    end else begin
      case (ph[d])
        P_IDLE, P_DONE, P_ERR: begin
          if (start) begin
            ph[d] = P_RECV; nb[d] = 0; maddr[d] = 0; mcnt[d] = 0;
          end
        end
        P_RECV: begin
          if (byte_valid) begin
            part[d][8*nb[d] +: 8] = byte_data;
            nb[d]++;
            if (nb[d] == 4) begin
              wlast[d] = part[d];
              nb[d]    = 0;
              ph[d]    = P_WRITE;
            end
          end
        end
        P_WRITE: begin
          mcnt[d]++;
          if (wlast[d] == 32'd0)  ph[d] = P_DONE;
          else if (maddr[d] == last) ph[d] = P_ERR;
          else begin
            maddr[d]++;
            ph[d] = P_RECV;
          end
        end
        default: ph[d] = P_IDLE;
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      wr_t w;
      if (bus5.imem_we) begin
        w.addr = int'(bus5.imem_addr); w.data = bus5.imem_wdata; log5.push_back(w);
      end
      if (bus2.imem_we) begin
        w.addr = int'(bus2.imem_addr); w.data = bus2.imem_wdata; log2.push_back(w);
      end
      model_step(0, bus5.byte_ready, bus5.imem_we, bus5.core_rst_n, bus5.done, bus5.err,
                 int'(bus5.imem_addr), bus5.imem_wdata, int'(bus5.word_count));
      model_step(1, bus2.byte_ready, bus2.imem_we, bus2.core_rst_n, bus2.done, bus2.err,
                 int'(bus2.imem_addr), bus2.imem_wdata, int'(bus2.word_count));
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one byte until the wide loader takes it (bounded).
  task automatic send_byte(input logic [7:0] b);
    bit acc;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int t = 0; t < 64; t++) begin
      acc = bus5.byte_ready;
      tick();
      if (acc) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        return;
      end
    end
    check("send_timeout", 32'(bus5.byte_ready), 32'd1);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    logic [31:0] v;
    v = w;
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        byte_data = 8'($urandom);
        tick();
      end
      send_byte(v[8*i +: 8]);
    end
  endtask

  task automatic wait_done5();
    for (int t = 0; t < 16; t++) begin
      if (bus5.done) break;
      tick();
    end
    check("wait_done", 32'(bus5.done), 32'd1);
  endtask

  task automatic check_log5(input string tag, input int idx, input int addr, input logic [31:0] data);
    if (idx < log5.size()) begin
      check({tag, ".addr"}, log5[idx].addr, addr);
      check({tag, ".data"}, log5[idx].data, data);
    end else begin
      check({tag, ".present"}, log5.size(), idx + 1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]  prog[12];
    logic [31:0] words[$];
    int          nw;

    prog = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h81, 8'h10, 8'h00,
             8'h00, 8'h00, 8'h00, 8'h00};

    @(posedge clk);
    #1;
    mon_on = 1'b1;
    repeat (2) tick();
    check("rst.byte_ready", 32'(bus5.byte_ready), 32'd0);
    check("rst.core_rst_n", 32'(bus5.core_rst_n), 32'd0);
    check("rst.imem_wdata", bus5.imem_wdata, 32'd0);
    rst = 1'b1;
    repeat (2) tick();

    // Reference program at one byte per cycle.
    log5.delete(); log2.delete();
    do_start();
    check("idle_start.byte_ready", 32'(bus5.byte_ready), 32'd1);
    foreach (prog[i]) send_byte(prog[i]);
    wait_done5();
    check("prog.nwrites", log5.size(), 3);
    check_log5("prog.w0", 0, 0, 32'h00500093);
    check_log5("prog.w1", 1, 1, 32'h00108113);
    check_log5("prog.w2", 2, 2, 32'h00000000);
    check("prog.word_count", int'(bus5.word_count), 3);
    check("prog.core_rst_n", 32'(bus5.core_rst_n), 32'd1);
    check("prog.a2_done", 32'(bus2.done), 32'd1);

    // Restart from DONE, then byte order with random gaps.
    log5.delete(); log2.delete();
    do_start();
    check("reload.core_rst_n", 32'(bus5.core_rst_n), 32'd0);
    check("reload.done", 32'(bus5.done), 32'd0);
    check("reload.word_count", int'(bus5.word_count), 0);
    send_word(32'h12345678, 3);
    send_word(32'h00000000, 3);
    wait_done5();
    check_log5("order.w0", 0, 0, 32'h12345678);
    check("order.word_count", int'(bus5.word_count), 2);

    // A byte held valid across WRITE becomes byte 0 of the next word.
    log5.delete(); log2.delete();
    do_start();
    send_word(32'h44332211, 0);
    send_word(32'h030201AA, 0);
    send_word(32'h00000000, 0);
    wait_done5();
    check_log5("pend.w0", 0, 0, 32'h44332211);
    check_log5("pend.w1", 1, 1, 32'h030201AA);

    // Four nonzero words overflow the small memory.
    log5.delete(); log2.delete();
    do_start();
    for (int i = 0; i < 4; i++) send_word(32'h0101_0101 * (i + 1), 1);
    tick();
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    repeat (4) tick();
    byte_valid = 1'b0;
    check("ovf.err", 32'(bus2.err), 32'd1);
    check("ovf.done", 32'(bus2.done), 32'd0);
    check("ovf.core_rst_n", 32'(bus2.core_rst_n), 32'd0);
    check("ovf.byte_ready", 32'(bus2.byte_ready), 32'd0);
    check("ovf.nwrites", log2.size(), 4);
    for (int i = 0; i < log2.size(); i++) check("ovf.addr", log2[i].addr, i);
    send_word(32'h00000000, 0);
    wait_done5();

    // Reset in the middle of a word discards the partial bytes.
    log5.delete(); log2.delete();
    do_start();
    send_byte(8'hAB);
    send_byte(8'hCD);
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("midrst.byte_ready", 32'(bus5.byte_ready), 32'd0);
    check("midrst.imem_addr", int'(bus5.imem_addr), 0);
    check("midrst.word_count", int'(bus5.word_count), 0);
    check("midrst.imem_wdata", bus5.imem_wdata, 32'd0);
    rst = 1'b1;
    tick();
    do_start();
    send_word(32'hCAFEF00D, 1);
    send_word(32'h00000000, 1);
    wait_done5();
    check_log5("midrst.w0", 0, 0, 32'hCAFEF00D);

    // Random programs, with stray start pulses mid-load.
    for (int it = 0; it < 30; it++) begin
      log5.delete(); log2.delete();
      words.delete();
      nw = $urandom_range(1, 6);
      for (int i = 0; i < nw; i++) words.push_back($urandom | 32'h0000_0100);
      words.push_back(32'h0);
      do_start();
      foreach (words[i]) begin
        if ($urandom_range(0, 5) == 0) do_start();
        send_word(words[i], 2);
      end
      wait_done5();
      check("rand.nwrites", log5.size(), words.size());
      foreach (words[i]) check_log5("rand.w", i, i, words[i]);
      repeat ($urandom_range(0, 3)) tick();
    end

    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
